// File: rtl/blake2_pkg.sv
// Shared Blake2s block-buffer constants, FSM state type and byte-lane helper.
package blake2_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int T_W         = 64;
  localparam int BLOCK_W     = BLOCK_BYTES * 8;
  localparam int IDX_W       = 6;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Bit offset of byte idx inside the little-endian packed block.
  function automatic logic [8:0] byte_lane(input logic [IDX_W-1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/blake2s_block_buffer.sv
// Gathers indexed message bytes into a zero-padded 64-byte Blake2s block, derives
// t and the final flag, and hands the block to the compressor over valid/ready.
module blake2s_block_buffer
  import blake2_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  input  logic               data_v_i,
  input  logic [7:0]         data_i,
  input  logic [IDX_W-1:0]   data_idx_i,
  input  logic               block_first_i,
  input  logic               block_last_i,
  input  logic               empty_msg_i,
  input  logic [7:0]         kk_i,
  input  logic [T_W-1:0]     ll_i,
  output logic               ready_o,
  output logic               block_v_o,
  input  logic               block_ready_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic [T_W-1:0]     t_o,
  output logic               first_o,
  output logic               last_o,
  output logic               overrun_o
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [T_W-1:0]     t_acc_q, t_acc_d;
  logic [T_W-1:0]     t_q, t_d;
  logic               got_q, got_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               overrun_q, overrun_d;

  logic               xfer;
  logic               accept;
  logic               complete;
  logic               empty_ok;
  logic [IDX_W-1:0]   last_idx;
  logic [T_W-1:0]     t_base;

  // Handoff cycle doubles as the first write slot of the next block.
  assign ready_o  = (state_q == FILL) | block_ready_i;
  assign xfer     = (state_q == HOLD) & block_ready_i;
  assign accept   = data_v_i & ready_o;
  assign last_idx = block_last_i ? (ll_i[IDX_W-1:0] - 6'd1) : 6'd63;
  assign complete = accept & (data_idx_i == last_idx);
  assign empty_ok = empty_msg_i & (state_q == FILL) & ~got_q & ~accept;
  assign t_base   = block_first_i ? {T_W{1'b0}} : t_acc_q;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    t_acc_d   = t_acc_q;
    t_d       = t_q;
    got_d     = got_q;
    first_d   = first_q;
    last_d    = last_q;
    overrun_d = overrun_q;

    if (xfer) begin
      buf_d   = '0;
      state_d = FILL;
      got_d   = 1'b0;
    end

    // Placed after the clear so a byte arriving during handoff survives it.
    if (accept) begin
      buf_d[byte_lane(data_idx_i) +: 8] = data_i;
      got_d = 1'b1;
    end

    if ((data_v_i & ~ready_o) | (empty_msg_i & ~empty_ok)) begin
      overrun_d = 1'b1;
    end

    if (complete) begin
      state_d = HOLD;
      got_d   = 1'b0;
      first_d = block_first_i;
      last_d  = block_last_i;
      if (block_last_i) begin
        t_d     = ll_i + ((kk_i != 8'd0) ? T_W'(BLOCK_BYTES) : {T_W{1'b0}});
        t_acc_d = '0;
      end else begin
        t_d     = t_base + T_W'(BLOCK_BYTES);
        t_acc_d = t_base + T_W'(BLOCK_BYTES);
      end
    end else if (empty_ok) begin
      state_d = HOLD;
      t_d     = '0;
      t_acc_d = '0;
      first_d = 1'b1;
      last_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= FILL;
      // NOTE: the block storage is reset too, because zero padding depends on it starting clear.
      buf_q     <= '0;
      t_acc_q   <= '0;
      t_q       <= '0;
      got_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      t_acc_q   <= t_acc_d;
      t_q       <= t_d;
      got_q     <= got_d;
      first_q   <= first_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign block_v_o = (state_q == HOLD);
  assign block_o   = buf_q;
  assign t_o       = t_q;
  assign first_o   = first_q;
  assign last_o    = last_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_blake2s_block_buffer.sv
// Bench for blake2s_block_buffer: vector table, directed corner sequences and a
// randomized run against a two-buffer (accumulating / presented) reference model.
module tb_blake2s_block_buffer;
  import blake2_pkg::*;

  logic         clk = 1'b0;
  logic         nreset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic         empty_msg_i;
  logic [7:0]   kk_i;
  logic [63:0]  ll_i;
  logic         ready_o;
  logic         block_v_o;
  logic         block_ready_i;
  logic [511:0] block_o;
  logic [63:0]  t_o;
  logic         first_o;
  logic         last_o;
  logic         overrun_o;

  always #5 clk = ~clk;

  blake2s_block_buffer dut (
    .clk           (clk),
    .nreset        (nreset),
    .data_v_i      (data_v_i),
    .data_i        (data_i),
    .data_idx_i    (data_idx_i),
    .block_first_i (block_first_i),
    .block_last_i  (block_last_i),
    .empty_msg_i   (empty_msg_i),
    .kk_i          (kk_i),
    .ll_i          (ll_i),
    .ready_o       (ready_o),
    .block_v_o     (block_v_o),
    .block_ready_i (block_ready_i),
    .block_o       (block_o),
    .t_o           (t_o),
    .first_o       (first_o),
    .last_o        (last_o),
    .overrun_o     (overrun_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bytes land in an accumulating block; a completed block is
  // copied to a separate presented block. t counts whole blocks of the hash.
  logic        m_hold;
  logic [7:0]  m_acc [64];
  logic [7:0]  m_out [64];
  bit          m_got;
  int unsigned m_nblk;
  logic [63:0] m_t;
  bit          m_first, m_last, m_ovr;

  task automatic model_reset();
    m_hold = 1'b0; m_got = 0; m_nblk = 0; m_t = '0;
    m_first = 0; m_last = 0; m_ovr = 0;
    for (int k = 0; k < 64; k++) begin m_acc[k] = '0; m_out[k] = '0; end
  endtask

  task automatic model_step();
    bit ready, accept, done, was_hold, had_bytes;
    logic [63:0] llm1;
    int lastidx;
    if (!nreset) begin model_reset(); return; end
    was_hold  = m_hold;
    had_bytes = m_got;
    ready     = !m_hold || block_ready_i;
    accept    = data_v_i && ready;
    done      = 0;
    if (m_hold && block_ready_i) m_hold = 1'b0;
    if (data_v_i && !ready) m_ovr = 1;
    if (accept) begin
      m_acc[int'(data_idx_i)] = data_i;
      m_got = 1;
      llm1 = ll_i - 64'd1;
      lastidx = block_last_i ? int'(llm1 % 64) : 63;
      if (int'(data_idx_i) == lastidx) done = 1;
    end
    if (empty_msg_i) begin
      if (was_hold || had_bytes || accept) m_ovr = 1;
      else begin
        for (int k = 0; k < 64; k++) m_out[k] = '0;
        m_hold = 1'b1; m_t = '0; m_first = 1; m_last = 1; m_nblk = 0;
      end
    end
    if (done) begin
      m_out = m_acc;
      for (int k = 0; k < 64; k++) m_acc[k] = '0;
      m_got = 0; m_hold = 1'b1;
      m_first = block_first_i; m_last = block_last_i;
      if (block_last_i) begin
        m_t = ll_i + ((kk_i != 0) ? 64'd64 : 64'd0);
        m_nblk = 0;
      end else begin
        if (block_first_i) m_nblk = 0;
        m_nblk++;
        m_t = 64'(m_nblk) * 64'd64;
      end
    end
  endtask

  function automatic logic [511:0] pack_out();
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[8*k +: 8] = m_out[k];
    return v;
  endfunction

  task automatic tick();
    #1;
    check("ready_o", 512'(ready_o), 512'(!m_hold || block_ready_i));
    @(posedge clk);
    model_step();
    #1;
    check("block_v_o", 512'(block_v_o), 512'(m_hold));
    check("t_o", 512'(t_o), 512'(m_t));
    check("first_o", 512'(first_o), 512'(m_first));
    check("last_o", 512'(last_o), 512'(m_last));
    check("overrun_o", 512'(overrun_o), 512'(m_ovr));
    if (m_hold) check("block_o", block_o, pack_out());
  endtask

  task automatic idle();
    data_v_i = 0; data_i = '0; data_idx_i = '0; empty_msg_i = 0;
  endtask

  task automatic do_reset();
    idle();
    nreset = 0; tick(); tick();
    nreset = 1;
  endtask

  task automatic send(input logic [7:0] d, input int idx);
    data_v_i = 1; data_i = d; data_idx_i = 6'(idx);
    tick();
    data_v_i = 0;
  endtask

  typedef struct {
    logic        dv;
    logic [7:0]  d;
    logic [5:0]  idx;
    logic        br;
    logic        e_rdy;
    logic        e_v;
    logic [63:0] e_t;
    logic        e_f, e_l, e_ovr;
    logic        chk_blk;
    logic [23:0] e_blk;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 8'h61, 6'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vecs[1] = '{1'b1, 8'h62, 6'd1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vecs[2] = '{1'b1, 8'h63, 6'd2, 1'b0, 1'b1, 1'b1, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1, 24'h636261};
    vecs[3] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1, 24'h636261};
    vecs[4] = '{1'b1, 8'hAA, 6'd5, 1'b0, 1'b0, 1'b1, 64'd3, 1'b1, 1'b1, 1'b1, 1'b1, 24'h636261};
    vecs[5] = '{1'b0, 8'h00, 6'd0, 1'b1, 1'b1, 1'b0, 64'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};

    model_reset();
    block_first_i = 0; block_last_i = 0; kk_i = '0; ll_i = '0; block_ready_i = 0;
    do_reset();
    check("reset block_v_o", 512'(block_v_o), 512'(0));
    check("reset t_o", 512'(t_o), 512'(0));
    check("reset block_o", block_o, 512'(0));

    // Unkeyed "abc": table of per-cycle stimulus and expected outputs.
    kk_i = 8'd0; ll_i = 64'd3; block_first_i = 1; block_last_i = 1;
    for (int i = 0; i < 6; i++) begin
      data_v_i = vecs[i].dv; data_i = vecs[i].d; data_idx_i = vecs[i].idx;
      block_ready_i = vecs[i].br;
      #1;
      check($sformatf("vec%0d ready_o", i), 512'(ready_o), 512'(vecs[i].e_rdy));
      tick();
      check($sformatf("vec%0d block_v_o", i), 512'(block_v_o), 512'(vecs[i].e_v));
      check($sformatf("vec%0d t_o", i), 512'(t_o), 512'(vecs[i].e_t));
      check($sformatf("vec%0d first_o", i), 512'(first_o), 512'(vecs[i].e_f));
      check($sformatf("vec%0d last_o", i), 512'(last_o), 512'(vecs[i].e_l));
      check($sformatf("vec%0d overrun_o", i), 512'(overrun_o), 512'(vecs[i].e_ovr));
      if (vecs[i].chk_blk) check($sformatf("vec%0d block_o", i), block_o, 512'(vecs[i].e_blk));
    end
    idle();
    do_reset();

    // ll=130: three blocks back to back, next block overlapping each handoff.
    kk_i = 0; ll_i = 64'd130; block_ready_i = 1;
    for (int b = 0; b < 3; b++) begin
      block_first_i = (b == 0);
      block_last_i  = (b == 2);
      for (int i = 0; i < ((b == 2) ? 2 : 64); i++) send(8'(b * 7 + i + 1), i);
      check($sformatf("ll130 blk%0d valid", b), 512'(block_v_o), 512'(1));
      check($sformatf("ll130 blk%0d t_o", b), 512'(t_o), 512'((b == 2) ? 130 : 64 * (b + 1)));
      check($sformatf("ll130 blk%0d last_o", b), 512'(last_o), 512'(b == 2));
      check($sformatf("ll130 blk%0d overrun", b), 512'(overrun_o), 512'(0));
    end
    check("ll130 tail zero", 512'(block_o[511:16]), 512'(0));
    check("ll130 head", 512'(block_o[15:0]), 512'(16'h100F));
    tick();

    // Keyed empty message: a single full key block, first and last.
    kk_i = 8'd32; ll_i = 64'd0; block_first_i = 1; block_last_i = 1;
    for (int i = 0; i < 64; i++) send(8'(8'h80 + i), i);
    check("keyed t_o", 512'(t_o), 512'(64));
    check("keyed last_o", 512'(last_o), 512'(1));

    // Compressor stalls ten cycles; a stray byte is dropped and flagged.
    block_ready_i = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) send(8'h5A, 3);
      else tick();
      check($sformatf("stall%0d t_o", c), 512'(t_o), 512'(64));
    end
    check("stall overrun", 512'(overrun_o), 512'(1));
    check("stall byte3 kept", 512'(block_o[31:24]), 512'(8'h83));
    block_ready_i = 1; tick();

    // Reset while holding a block discards it.
    kk_i = 0; ll_i = 64'd2; block_ready_i = 0;
    send(8'h11, 0); send(8'h22, 1);
    check("pre-reset hold", 512'(block_v_o), 512'(1));
    do_reset();
    check("post-reset valid", 512'(block_v_o), 512'(0));
    check("post-reset t_o", 512'(t_o), 512'(0));
    check("post-reset overrun", 512'(overrun_o), 512'(0));
    ll_i = 64'd1;
    send(8'h41, 0);
    check("ll1 t_o", 512'(t_o), 512'(1));
    block_ready_i = 1; tick();

    // Unkeyed empty message pulse, then a pulse while holding.
    block_ready_i = 0;
    empty_msg_i = 1; tick(); empty_msg_i = 0;
    check("empty valid", 512'(block_v_o), 512'(1));
    check("empty t_o", 512'(t_o), 512'(0));
    check("empty first/last", 512'({first_o, last_o}), 512'(2'b11));
    check("empty block", block_o, 512'(0));
    check("empty no overrun", 512'(overrun_o), 512'(0));
    empty_msg_i = 1; tick(); empty_msg_i = 0;
    check("empty in hold overrun", 512'(overrun_o), 512'(1));
    block_ready_i = 1; tick();

    // Randomized traffic against the model.
    do_reset();
    begin
      int seq_idx = 0;
      for (int c = 0; c < 3000; c++) begin
        nreset        = ($urandom % 150) != 0;
        data_v_i      = ($urandom % 4) != 0;
        data_i        = 8'($urandom);
        if ($urandom % 2) data_idx_i = 6'(seq_idx);
        else data_idx_i = 6'($urandom % 64);
        if (data_v_i) seq_idx = (seq_idx + 1) % 64;
        block_ready_i = ($urandom % 3) != 0;
        block_first_i = ($urandom % 4) == 0;
        block_last_i  = ($urandom % 4) == 0;
        empty_msg_i   = ($urandom % 40) == 0;
        kk_i          = ($urandom % 2) ? 8'd32 : 8'd0;
        case ($urandom % 4)
          0: ll_i = 64'($urandom % 200);
          1: ll_i = 64'd0;
          2: ll_i = 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom % 64);
          default: ll_i = {$urandom, $urandom};
        endcase
        tick();
      end
    end
    nreset = 1;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
